// File: rtl/zba_decode_stage_if.sv
// Handshake bundle for the Zba decode stage: upstream word + operands in, decoded result out.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs on each side.
interface zba_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_inst;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_result;
  logic            out_illegal;

  // Producer/consumer side (register read upstream, writeback downstream).
  modport master (
    output in_valid, instr, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, out_inst, out_rd, out_result, out_illegal
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, out_inst, out_rd, out_result, out_illegal
  );
endinterface

// File: rtl/zba_decode_stage.sv
// Decodes sh1add/sh2add/sh3add, computes (rs1<<n)+rs2 and queues it in a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when the buffer is empty.
// Backpressure: in_ready is registered (count<2); no combinational path from out_ready.
module zba_decode_stage #(
  parameter int XLEN         = 32,
  parameter bit DROP_ILLEGAL = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  zba_decode_stage_if.slave   bus,
  output logic [15:0]         op_count
);

  typedef struct packed {
    logic [1:0]      inst;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  logic [1:0] dec_n;
  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       in_ready_q;
  logic       accept;
  logic       enq;
  logic       deq;
  logic       unused_instr;

  // rs1/rs2 register-number fields are already resolved into rs1_val/rs2_val upstream.
  assign unused_instr = ^bus.instr[24:15];

  // Decode the instruction word and form the shift-add result (zero for non-Zba words).
  always_comb begin
    dec_n       = 2'd0;
    dec.inst    = 2'b11;
    dec.rd      = bus.instr[11:7];
    dec.illegal = 1'b1;
    dec.result  = '0;
    if (bus.instr[6:0] == 7'b0110011 && bus.instr[31:25] == 7'b0010000) begin
      case (bus.instr[14:12])
        3'b010:  begin dec.inst = 2'b00; dec_n = 2'd1; dec.illegal = 1'b0; end
        3'b100:  begin dec.inst = 2'b01; dec_n = 2'd2; dec.illegal = 1'b0; end
        3'b110:  begin dec.inst = 2'b10; dec_n = 2'd3; dec.illegal = 1'b0; end
        default: ;
      endcase
    end
    if (!dec.illegal) begin
      dec.result = (bus.rs1_val << dec_n) + bus.rs2_val;
    end
  end

  // Flush wins over both sides of the handshake; dropped illegal words still complete the handshake.
  assign accept = bus.in_valid & in_ready_q;
  assign enq    = accept & ~flush & (~dec.illegal | ~DROP_ILLEGAL);
  assign deq    = (count != 2'd0) & bus.out_ready & ~flush;

  // Occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      case ({enq, deq})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end
  end

  // Pointers, occupancy and the registered ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      count      <= count_nxt;
      in_ready_q <= (count_nxt < 2'd2);
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (enq) wr_ptr <= ~wr_ptr;
        if (deq) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Entry storage; only the tail slot is written so the head stays stable under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i].inst    <= 2'b11;
        mem[i].rd      <= 5'd0;
        mem[i].result  <= '0;
        mem[i].illegal <= 1'b0;
      end
    end else if (enq) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Saturating count of legal ops handed downstream; flush does not clear it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= 16'd0;
    end else if (deq && !mem[rd_ptr].illegal && op_count != 16'hFFFF) begin
      op_count <= op_count + 16'd1;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_inst    = mem[rd_ptr].inst;
  assign bus.out_rd      = mem[rd_ptr].rd;
  assign bus.out_result  = mem[rd_ptr].result;
  assign bus.out_illegal = mem[rd_ptr].illegal;

endmodule
